txn_timeout_monitor: RTL

- Next-generation per-channel transaction timeout monitor.
- Tracks up to NUM_CH outstanding transactions, each with a programmable timeout, prescaled tick and optional exponential backoff per retry.
- Issues retry and abort pulses, and reports events through a buffered valid/ready event stream with round-robin fairness.
- Sits between the channel engines and the host/error logger.

---
 rtl/txn_wdog_pkg.sv | 31 +++
 rtl/txn_timeout_monitor_if.sv | 34 +++
 rtl/txn_wdog_evt_fifo.sv | 62 ++++++
 rtl/txn_timeout_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/txn_wdog_pkg.sv
// Shared types and constants for the transaction timeout monitor.
// Channel states, event codes, severities and event bundles.
package txn_wdog_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } ch_state_e;

  localparam logic [7:0] EVT_TO_RETRY  = 8'h10;
  localparam logic [7:0] EVT_TO_ABORT  = 8'h11;
  localparam logic [7:0] EVT_SPUR_DONE = 8'h12;

  localparam logic [3:0] SEV_INFO  = 4'd1;
  localparam logic [3:0] SEV_RECOV = 4'd2;
  localparam logic [3:0] SEV_FATAL = 4'd3;

  localparam int CH_W_MAX = 5;

  typedef struct packed {
    logic [3:0]          sev;
    logic [7:0]          code;
    logic [CH_W_MAX-1:0] ch;
  } evt_t;

  typedef struct packed {
    logic [3:0] sev;
    logic [7:0] code;
  } slot_t;

endpackage

// File: rtl/txn_timeout_monitor_if.sv
// Event stream handshake between the monitor and the host logger.
// Master drives the event fields, slave returns ready.
interface txn_timeout_monitor_if #(
  parameter int NUM_CH = 8
);

  localparam int CH_W = $clog2(NUM_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [3:0]      evt_severity;
  logic [7:0]      evt_code;
  logic [CH_W-1:0] evt_ch;
  logic [7:0]      evt_drop_cnt;

  modport master (
    output evt_valid,
    output evt_severity,
    output evt_code,
    output evt_ch,
    output evt_drop_cnt,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_severity,
    input  evt_code,
    input  evt_ch,
    input  evt_drop_cnt,
    output evt_ready
  );

endinterface

// File: rtl/txn_wdog_evt_fifo.sv
// First-word-fall-through synchronous FIFO for monitor events.
// Head entry is visible on dout whenever the FIFO is non-empty.
module txn_wdog_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full from empty.
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/txn_timeout_monitor.sv
// Per-channel transaction timeout monitor with retry/abort pulses,
// exponential backoff and a round-robin buffered event stream.
module txn_timeout_monitor
  import txn_wdog_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int TIMER_W    = 16,
  parameter int RETRY_W    = 2,
  parameter int PRESCALE_W = 8,
  parameter int EVT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     cfg_enable,
  input  logic [TIMER_W-1:0]    cfg_timeout,
  input  logic [RETRY_W-1:0]    cfg_retry_max,
  input  logic                  cfg_backoff_en,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic [NUM_CH-1:0]     tr_start,
  input  logic [NUM_CH-1:0]     tr_done,
  output logic [NUM_CH-1:0]     tr_retry,
  output logic [NUM_CH-1:0]     tr_abort,
  output logic [NUM_CH-1:0]     ch_busy,
  txn_timeout_monitor_if.master evt
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int LIM_W = TIMER_W + 2**RETRY_W;

  localparam logic [TIMER_W-1:0] TMAX = {TIMER_W{1'b1}};

  ch_state_e            state_q [NUM_CH];
  ch_state_e            state_d [NUM_CH];
  logic [TIMER_W-1:0]   timer_q [NUM_CH];
  logic [TIMER_W-1:0]   timer_d [NUM_CH];
  logic [RETRY_W-1:0]   retry_q [NUM_CH];
  logic [RETRY_W-1:0]   retry_d [NUM_CH];
  slot_t                slot_q  [NUM_CH];
  slot_t                slot_d  [NUM_CH];
  slot_t                new_slot [NUM_CH];
  logic [NUM_CH-1:0]    new_vld;
  logic [NUM_CH-1:0]    pend_q, pend_d;
  logic [NUM_CH-1:0]    rty_p_q, rty_p_d;
  logic [NUM_CH-1:0]    abt_p_q, abt_p_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                 tick;
  logic [CH_W-1:0]      rr_q, rr_d;
  logic [7:0]           drop_q, drop_d;
  logic                 gnt_vld;
  logic [CH_W-1:0]      gnt_idx;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  evt_t                 push_evt;
  evt_t                 head_evt;
  logic                 unused_ch;

  function automatic logic [TIMER_W-1:0] calc_limit(
    input logic [TIMER_W-1:0] to,
    input logic [RETRY_W-1:0] r,
    input logic               bo
  );
    logic [LIM_W-1:0] ext;
    ext = LIM_W'(to);
    if (bo) ext = ext << r;
    if (|ext[LIM_W-1:TIMER_W]) return TMAX;
    return ext[TIMER_W-1:0];
  endfunction

  assign tick    = presc_q == cfg_prescale;
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_comb begin : ch_fsm
    logic [TIMER_W-1:0] lim;
    logic [TIMER_W:0]   tinc;
    lim  = '0;
    tinc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      timer_d[i]  = timer_q[i];
      retry_d[i]  = retry_q[i];
      rty_p_d[i]  = 1'b0;
      abt_p_d[i]  = 1'b0;
      new_vld[i]  = 1'b0;
      new_slot[i] = '0;
      lim  = calc_limit(cfg_timeout, retry_q[i],
                        cfg_backoff_en);
      tinc = {1'b0, timer_q[i]} + 1'b1;
      if (!cfg_enable[i]) begin
        state_d[i] = IDLE;
        timer_d[i] = '0;
        retry_d[i] = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (tr_done[i]) begin
              new_vld[i]  = 1'b1;
              new_slot[i] = '{sev: SEV_INFO,
                              code: EVT_SPUR_DONE};
            end else if (tr_start[i]) begin
              state_d[i] = ARMED;
              timer_d[i] = '0;
              retry_d[i] = '0;
            end
          end
          ARMED: begin
            if (tr_done[i]) begin
              state_d[i] = IDLE;
              timer_d[i] = '0;
              retry_d[i] = '0;
            end else if (tr_start[i]) begin
              timer_d[i] = '0;
            end else if (tick && cfg_timeout != '0) begin
              // >= so a lowered limit expires on the next tick
              if (tinc >= {1'b0, lim}) begin
                timer_d[i] = '0;
                if (retry_q[i] < cfg_retry_max) begin
                  retry_d[i]  = retry_q[i] + 1'b1;
                  rty_p_d[i]  = 1'b1;
                  new_vld[i]  = 1'b1;
                  new_slot[i] = '{sev: SEV_RECOV,
                                  code: EVT_TO_RETRY};
                end else begin
                  state_d[i]  = IDLE;
                  retry_d[i]  = '0;
                  abt_p_d[i]  = 1'b1;
                  new_vld[i]  = 1'b1;
                  new_slot[i] = '{sev: SEV_FATAL,
                                  code: EVT_TO_ABORT};
                end
              end else begin
                timer_d[i] = tinc[TIMER_W-1:0];
              end
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin : rr_arb
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!gnt_vld && pend_q[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(j);
      end
    end
  end

  assign push = gnt_vld && !fifo_full;

  always_comb begin
    rr_d = rr_q;
    if (push) begin
      rr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ?
             '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    push_evt.sev  = slot_q[gnt_idx].sev;
    push_evt.code = slot_q[gnt_idx].code;
    push_evt.ch   = CH_W_MAX'(gnt_idx);
  end

  // A slot granted this cycle frees up before the new event lands.
  always_comb begin
    pend_d = pend_q;
    slot_d = slot_q;
    drop_d = drop_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (push && gnt_idx == CH_W'(i)) begin
        pend_d[i] = 1'b0;
      end
      if (new_vld[i]) begin
        if (pend_d[i] && drop_d != 8'hFF) begin
          drop_d = drop_d + 8'd1;
        end
        pend_d[i] = 1'b1;
        slot_d[i] = new_slot[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
      pend_q  <= '0;
      rty_p_q <= '0;
      abt_p_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
        retry_q[i] <= '0;
        slot_q[i]  <= '0;
      end
    end else begin
      presc_q <= presc_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      rty_p_q <= rty_p_d;
      abt_p_q <= abt_p_d;
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      slot_q  <= slot_d;
    end
  end

  txn_wdog_evt_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (EVT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_evt),
    .pop   (pop),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop = !fifo_empty && evt.evt_ready;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_busy[i] = state_q[i] == ARMED;
    end
  end

  assign tr_retry         = rty_p_q;
  assign tr_abort         = abt_p_q;
  assign evt.evt_valid    = !fifo_empty;
  assign evt.evt_severity = head_evt.sev;
  assign evt.evt_code     = head_evt.code;
  assign evt.evt_ch       = head_evt.ch[CH_W-1:0];
  assign evt.evt_drop_cnt = drop_q;
  assign unused_ch        = ^head_evt.ch;

endmodule
